sr_cmd_gen: RTL

Input-conditioning stage that sits directly upstream of `sr_ff`. It synchronises and debounces two board pushbuttons (set, reset) and converts each accepted press into a single-cycle `S` or `R` command pulse. It guarantees that `S` and `R` are never asserted in the same cycle, so the forbidden S=R=1 condition never reaches the flip-flop. Outputs connect straight to `sr_ff` `.S`/`.R` on the same `clk`.

---
 rtl/sr_cmd_pkg.sv | 10 +
 rtl/sr_cmd_gen_btn_debounce.sv | 67 ++++++
 rtl/sr_cmd_gen.sv | 46 ++++
 3 files changed

// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared debounce FSM state encoding and conflict counter width for sr_cmd_gen
package sr_cmd_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;
  localparam int CONFLICT_CNT_W = 8;
endpackage

// File: rtl/sr_cmd_gen_btn_debounce.sv
// btn_debounce: 2-flop synchroniser + debounce FSM, one registered accept strobe per debounced press
// Ports: clk, rst_n (async active-low), btn (raw async button), accept (one-cycle press strobe)
module btn_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic accept
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] CNT_MAX = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] CNT_ONE = W'(1);
  logic [1:0] sync_q;
  logic sync;
  db_state_t state, state_d;
  logic [W-1:0] cnt, cnt_d;
  logic accept_d;
  assign sync = sync_q[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      state  <= IDLE;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      state  <= state_d;
      cnt    <= cnt_d;
      accept <= accept_d;
    end
  end
  // cnt only increments below CNT_MAX, so it saturates instead of wrapping
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    accept_d = 1'b0;
    case (state)
      IDLE: if (sync) begin
        state_d = PRESS_WAIT;
        cnt_d   = CNT_ONE;
      end
      PRESS_WAIT: if (!sync) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt == CNT_MAX) begin
        state_d  = PRESSED;
        cnt_d    = '0;
        accept_d = 1'b1;
      end else cnt_d = cnt + 1'b1;
      PRESSED: if (!sync) begin
        state_d = RELEASE_WAIT;
        cnt_d   = CNT_ONE;
      end
      RELEASE_WAIT: if (sync) begin
        state_d = PRESSED;
        cnt_d   = '0;
      end else if (cnt == CNT_MAX) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt + 1'b1;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced set/reset buttons -> mutually exclusive one-cycle S/R commands for sr_ff
// Ports: clk, rst_n (async active-low), btn_set, btn_reset (raw buttons),
//        S, R (one-cycle commands), conflict (both accepted together, both dropped),
//        conflict_cnt (saturating conflict count, only with SR_CMD_GEN_CONFLICT_CNT_EN defined)
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic S,
  output logic R,
  output logic conflict
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  ,output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);
  logic set_acc, rst_acc;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk), .rst_n(rst_n), .btn(btn_set), .accept(set_acc)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
    .clk(clk), .rst_n(rst_n), .btn(btn_reset), .accept(rst_acc)
  );
  // simultaneous accepts are both dropped so S=R=1 can never reach the flip-flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= set_acc & ~rst_acc;
      R        <= rst_acc & ~set_acc;
      conflict <= set_acc & rst_acc;
    end
  end
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt <= '0;
    else if (conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
  end
`endif
endmodule
